// File: rtl/uart_tx_arbiter.sv
// ============================================================================
// Module  : uart_tx_arbiter
// Brief   : Round-robin scheduler of button and rx-echo bytes onto one UART
//           transmit serializer, with start/busy handshake and busy timeout.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module uart_tx_arbiter #(
  parameter int DATA_W       = 8,
  parameter int BUSY_TIMEOUT = 1024
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              btn_level_i,
  input  logic [DATA_W-1:0] sw_data_i,
  input  logic              rx_valid_i,
  input  logic [DATA_W-1:0] rx_data_i,
  input  logic              tx_busy_i,
  output logic              tx_start_o,
  output logic [DATA_W-1:0] tx_data_o,
  output logic              grant_src_o,
  output logic              btn_ovf_o,
  output logic              rx_ovf_o,
  output logic              tx_done_o,
  output logic              tx_fault_o
);

  localparam int              CNT_W    = (BUSY_TIMEOUT > 1) ? $clog2(BUSY_TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BUSY_TIMEOUT - 1);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WAIT_BUSY = 2'd1,
    WAIT_DONE = 2'd2
  } state_e;

  state_e            state_q;
  logic [CNT_W-1:0]  cnt_q;
  logic              btn_q;
  logic              btn_pend_q;
  logic              rx_pend_q;
  logic              last_grant_q;
  logic [DATA_W-1:0] btn_buf_q;
  logic [DATA_W-1:0] rx_buf_q;
  logic [DATA_W-1:0] tx_data_q;
  logic              tx_start_q;
  logic              grant_src_q;
  logic              btn_ovf_q;
  logic              rx_ovf_q;
  logic              tx_done_q;
  logic              tx_fault_q;

  logic press_d;
  logic grant_d;
  logic grant_sel_d;
  logic grant_btn_d;
  logic grant_rx_d;

  always_comb begin
    press_d     = btn_level_i & ~btn_q;
    grant_d     = (state_q == IDLE) & (btn_pend_q | rx_pend_q) & ~tx_busy_i;
    // On a tie the source that did not win last time gets the serializer.
    grant_sel_d = (btn_pend_q & rx_pend_q) ? ~last_grant_q : ~btn_pend_q;
    grant_btn_d = grant_d & ~grant_sel_d;
    grant_rx_d  = grant_d &  grant_sel_d;
  end

  // A new event in the cycle its source is granted refills the buffer:
  // the old byte leaves this edge, so nothing is dropped.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      btn_q      <= 1'b1;
      btn_pend_q <= 1'b0;
      rx_pend_q  <= 1'b0;
      btn_buf_q  <= '0;
      rx_buf_q   <= '0;
      btn_ovf_q  <= 1'b0;
      rx_ovf_q   <= 1'b0;
    end else begin
      btn_q     <= btn_level_i;
      btn_ovf_q <= 1'b0;
      rx_ovf_q  <= 1'b0;

      if (press_d) begin
        if (!btn_pend_q || grant_btn_d) begin
          btn_buf_q  <= sw_data_i;
          btn_pend_q <= 1'b1;
        end else begin
          btn_ovf_q <= 1'b1;
        end
      end else if (grant_btn_d) begin
        btn_pend_q <= 1'b0;
      end

      if (rx_valid_i) begin
        if (!rx_pend_q || grant_rx_d) begin
          rx_buf_q  <= rx_data_i;
          rx_pend_q <= 1'b1;
        end else begin
          rx_ovf_q <= 1'b1;
        end
      end else if (grant_rx_d) begin
        rx_pend_q <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      last_grant_q <= 1'b1;
      tx_start_q   <= 1'b0;
      tx_data_q    <= '0;
      grant_src_q  <= 1'b0;
      tx_done_q    <= 1'b0;
      tx_fault_q   <= 1'b0;
    end else begin
      tx_start_q <= 1'b0;
      tx_done_q  <= 1'b0;
      tx_fault_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (grant_d) begin
            tx_data_q    <= grant_sel_d ? rx_buf_q : btn_buf_q;
            grant_src_q  <= grant_sel_d;
            last_grant_q <= grant_sel_d;
            tx_start_q   <= 1'b1;
            cnt_q        <= '0;
            state_q      <= WAIT_BUSY;
          end
        end
        WAIT_BUSY: begin
          if (tx_busy_i) begin
            cnt_q   <= '0;
            state_q <= WAIT_DONE;
          end else if (cnt_q == CNT_LAST) begin
            // Serializer never answered: drop the byte rather than retry.
            tx_fault_q <= 1'b1;
            cnt_q      <= '0;
            state_q    <= IDLE;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        WAIT_DONE: begin
          if (!tx_busy_i) begin
            tx_done_q <= 1'b1;
            state_q   <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign tx_start_o  = tx_start_q;
  assign tx_data_o   = tx_data_q;
  assign grant_src_o = grant_src_q;
  assign btn_ovf_o   = btn_ovf_q;
  assign rx_ovf_o    = rx_ovf_q;
  assign tx_done_o   = tx_done_q;
  assign tx_fault_o  = tx_fault_q;

endmodule

`default_nettype wire

// File: tb/tb_uart_tx_arbiter.sv
// ============================================================================
// Module  : tb_uart_tx_arbiter
// Brief   : Directed self-checking bench for uart_tx_arbiter with a simple
//           serializer busy model.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_uart_tx_arbiter;

  localparam int DATA_W       = 8;
  localparam int BUSY_TIMEOUT = 16;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              btn_level = 1'b0;
  logic [DATA_W-1:0] sw_data = '0;
  logic              rx_valid = 1'b0;
  logic [DATA_W-1:0] rx_data = '0;
  logic              tx_busy;
  logic              tx_start;
  logic [DATA_W-1:0] tx_data;
  logic              grant_src;
  logic              btn_ovf;
  logic              rx_ovf;
  logic              tx_done;
  logic              tx_fault;

  int   n_cmp = 0;
  int   n_bad = 0;
  int   cyc = 0;
  logic model_en = 1'b1;
  int   busy_len = 100;

  logic [8:0] launch_q[$];
  int done_cnt = 0;
  int fault_cnt = 0;
  int btn_ovf_cnt = 0;
  int rx_ovf_cnt = 0;
  int start_cyc = 0;
  int fault_cyc = 0;

  uart_tx_arbiter #(
    .DATA_W       (DATA_W),
    .BUSY_TIMEOUT (BUSY_TIMEOUT)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .btn_level_i (btn_level),
    .sw_data_i   (sw_data),
    .rx_valid_i  (rx_valid),
    .rx_data_i   (rx_data),
    .tx_busy_i   (tx_busy),
    .tx_start_o  (tx_start),
    .tx_data_o   (tx_data),
    .grant_src_o (grant_src),
    .btn_ovf_o   (btn_ovf),
    .rx_ovf_o    (rx_ovf),
    .tx_done_o   (tx_done),
    .tx_fault_o  (tx_fault)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Serializer: busy rises one cycle after the start strobe, holds busy_len cycles.
  initial begin
    tx_busy = 1'b0;
    forever begin
      @(negedge clk);
      if (model_en && tx_start === 1'b1) begin
        @(negedge clk);
        tx_busy = 1'b1;
        repeat (busy_len) @(negedge clk);
        tx_busy = 1'b0;
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (tx_start === 1'b1) begin
        launch_q.push_back({grant_src, tx_data});
        start_cyc = cyc;
      end
      if (tx_done === 1'b1) done_cnt++;
      if (tx_fault === 1'b1) begin
        fault_cnt++;
        fault_cyc = cyc;
      end
      if (btn_ovf === 1'b1) btn_ovf_cnt++;
      if (rx_ovf === 1'b1) rx_ovf_cnt++;
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic check_launch(input string tag, input int idx, input logic src, input logic [7:0] data);
    if (idx < launch_q.size()) check_val(tag, 32'(launch_q[idx]), 32'({src, data}));
    else check_val({tag, "_count"}, 32'(launch_q.size()), 32'(idx + 1));
  endtask

  task automatic wait_launch(input int n, input int budget);
    for (int i = 0; i < budget && launch_q.size() < n; i++) @(negedge clk);
  endtask

  task automatic wait_done(input int n, input int budget);
    for (int i = 0; i < budget && done_cnt < n; i++) @(negedge clk);
  endtask

  task automatic wait_busy(input string tag);
    for (int i = 0; i < 50 && tx_busy !== 1'b1; i++) @(negedge clk);
    check_val(tag, 32'(tx_busy), 32'd1);
  endtask

  task automatic press(input logic [7:0] data);
    @(negedge clk);
    btn_level = 1'b0;
    @(negedge clk);
    btn_level = 1'b1;
    sw_data   = data;
  endtask

  task automatic rx_strobe(input logic [7:0] data);
    @(negedge clk);
    rx_valid = 1'b1;
    rx_data  = data;
    @(negedge clk);
    rx_valid = 1'b0;
  endtask

  task automatic pair(input logic [7:0] bdata, input logic [7:0] rdata);
    @(negedge clk);
    btn_level = 1'b0;
    @(negedge clk);
    btn_level = 1'b1;
    sw_data   = bdata;
    rx_valid  = 1'b1;
    rx_data   = rdata;
    @(negedge clk);
    rx_valid = 1'b0;
  endtask

  task automatic apply_reset(input logic hold_btn);
    for (int i = 0; i < 400 && tx_busy === 1'b1; i++) @(negedge clk);
    @(negedge clk);
    rst_n     = 1'b0;
    btn_level = hold_btn;
    rx_valid  = 1'b0;
    repeat (3) @(negedge clk);
    launch_q.delete();
    done_cnt    = 0;
    fault_cnt   = 0;
    btn_ovf_cnt = 0;
    rx_ovf_cnt  = 0;
    rst_n = 1'b1;
  endtask

  initial begin
    // Reset values
    repeat (3) @(negedge clk);
    check_val("rst_tx_start", 32'(tx_start), 32'd0);
    check_val("rst_tx_data", 32'(tx_data), 32'd0);
    check_val("rst_grant_src", 32'(grant_src), 32'd0);
    check_val("rst_pulses", 32'({btn_ovf, rx_ovf, tx_done, tx_fault}), 32'd0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Single press: launch two clocks after press, one-cycle strobe
    busy_len  = 100;
    btn_level = 1'b1;
    sw_data   = 8'h41;
    @(negedge clk);
    check_val("lat_k1_start", 32'(tx_start), 32'd0);
    @(negedge clk);
    check_val("lat_k2_start", 32'(tx_start), 32'd1);
    check_val("lat_k2_data", 32'(tx_data), 32'h41);
    check_val("lat_k2_src", 32'(grant_src), 32'd0);
    @(negedge clk);
    check_val("start_one_cycle", 32'(tx_start), 32'd0);
    wait_done(1, 200);
    check_val("single_done", 32'(done_cnt), 32'd1);
    check_val("single_data_held", 32'(tx_data), 32'h41);
    repeat (30) @(negedge clk);
    check_val("single_launches", 32'(launch_q.size()), 32'd1);

    // Simultaneous pairs: round-robin tie break
    apply_reset(1'b0);
    busy_len = 20;
    repeat (2) @(negedge clk);
    pair(8'h33, 8'h5A);
    wait_launch(2, 200);
    check_launch("pair1_first", 0, 1'b0, 8'h33);
    check_launch("pair1_second", 1, 1'b1, 8'h5A);
    wait_done(2, 200);
    press(8'h10);
    wait_launch(3, 30);
    check_launch("single_mid", 2, 1'b0, 8'h10);
    wait_done(3, 200);
    pair(8'h44, 8'hC3);
    wait_launch(5, 200);
    check_launch("pair2_first", 3, 1'b1, 8'hC3);
    check_launch("pair2_second", 4, 1'b0, 8'h44);
    wait_done(5, 200);
    check_val("pair_ovf", 32'(btn_ovf_cnt + rx_ovf_cnt), 32'd0);

    // Rx overflow during a busy frame
    apply_reset(1'b0);
    busy_len = 30;
    press(8'hA0);
    wait_launch(1, 30);
    wait_busy("ovf_busy");
    rx_strobe(8'h01);
    rx_strobe(8'h02);
    rx_strobe(8'h03);
    @(negedge clk);
    check_val("rx_ovf_count", 32'(rx_ovf_cnt), 32'd2);
    wait_launch(2, 200);
    check_launch("ovf_first", 0, 1'b0, 8'hA0);
    check_launch("ovf_kept", 1, 1'b1, 8'h01);
    wait_done(2, 200);
    repeat (20) @(negedge clk);
    check_val("ovf_launches", 32'(launch_q.size()), 32'd2);

    // Button held through reset release gives no press
    apply_reset(1'b1);
    busy_len = 20;
    repeat (50) @(negedge clk);
    check_val("held_no_launch", 32'(launch_q.size()), 32'd0);
    press(8'h77);
    wait_launch(1, 30);
    check_launch("held_repress", 0, 1'b0, 8'h77);
    wait_done(1, 200);
    check_val("held_one_launch", 32'(launch_q.size()), 32'd1);

    // Busy timeout with the serializer silent
    apply_reset(1'b0);
    model_en = 1'b0;
    press(8'h99);
    wait_launch(1, 30);
    check_launch("to_launch", 0, 1'b0, 8'h99);
    for (int i = 0; i < 60 && fault_cnt < 1; i++) @(negedge clk);
    check_val("to_fault_cnt", 32'(fault_cnt), 32'd1);
    check_val("to_fault_delay", 32'(fault_cyc - start_cyc), 32'd16);
    repeat (40) @(negedge clk);
    check_val("to_no_retry", 32'(launch_q.size()), 32'd1);
    check_val("to_no_done", 32'(done_cnt), 32'd0);
    model_en = 1'b1;
    busy_len = 20;
    press(8'h5C);
    wait_launch(2, 30);
    check_launch("to_idle_again", 1, 1'b0, 8'h5C);
    wait_done(1, 200);

    // Reset during WAIT_DONE with rx pending
    apply_reset(1'b0);
    busy_len = 40;
    press(8'hB5);
    wait_launch(1, 30);
    wait_busy("mid_busy");
    rx_strobe(8'h55);
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_val("mid_rst_start", 32'(tx_start), 32'd0);
    check_val("mid_rst_data", 32'(tx_data), 32'd0);
    check_val("mid_rst_src", 32'(grant_src), 32'd0);
    check_val("mid_rst_pulses", 32'({btn_ovf, rx_ovf, tx_done, tx_fault}), 32'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (80) @(negedge clk);
    check_val("mid_no_launch", 32'(launch_q.size()), 32'd1);
    check_val("mid_no_done", 32'(done_cnt), 32'd0);
    rx_strobe(8'h66);
    wait_launch(2, 30);
    check_launch("mid_new_req", 1, 1'b1, 8'h66);
    wait_done(1, 200);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
